mmio_result_port: RTL and testbench

//  Memory-mapped result/console peripheral on the single-cycle RV32I core's data-store bus (MemWrite/DataAdr/WriteData).

---
 rtl/mmio_result_pkg.sv | 8 +
 rtl/mmio_result_port_sync_fifo.sv | 46 ++++
 rtl/mmio_result_port.sv | 86 ++++++++
 tb/tb_mmio_result_port.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mmio_result_pkg.sv
// mmio_result_pkg: status encoding and default MMIO map shared by mmio_result_port
package mmio_result_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} status_e;
    localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA    = 32'd25;
    localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_0F00;
endpackage

// File: rtl/mmio_result_port_sync_fifo.sv
// sync_fifo: single-clock FIFO, valid/ready pop side, push side reports dropped writes
//  clk, rst_n      clock, synchronous active-low reset (contents discarded)
//  push, din       write request and data
//  drop            push refused because the FIFO was full and nothing popped this edge
//  valid, ready    pop handshake; pop when valid && ready
//  dout            head entry, 0 while empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             drop,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic full, pop, wr;
    assign valid = count != '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign pop   = valid && ready;
    // a pop on the same edge frees the slot, so a full FIFO can still accept
    assign wr    = push && (!full || pop);
    assign drop  = push && !wr;
    assign dout  = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/mmio_result_port.sv
// mmio_result_port: observes core stores and decides PASS/FAIL/TIMEOUT, buffers console bytes
//  clk, rst_n                    clock, synchronous active-low reset
//  MemWrite, DataAdr, WriteData  core store bus (observed only)
//  con_valid, con_ready, con_data console byte stream (FIFO head)
//  status, done                  verdict and verdict-reached flag
//  store_cnt                     saturating count of stores seen while running
//  overflow                      sticky: a console byte was dropped
//  Macro MMIO_RESULT_PORT_CONSOLE_EN enables the console FIFO; otherwise console stores are discarded.
module mmio_result_port
    import mmio_result_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
    parameter logic [31:0] CONSOLE_ADDR   = DEF_CONSOLE_ADDR,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data,
    output status_e     status,
    output logic        done,
    output logic [15:0] store_cnt,
    output logic        overflow
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    status_e status_nx;
    logic [TW-1:0] tcnt;
    logic store, hit_pass, hit_con, legal, t_last;
    assign store    = MemWrite && status == ST_RUN;
    assign hit_pass = DataAdr == PASS_ADDR;
    assign hit_con  = DataAdr == CONSOLE_ADDR;
    assign legal    = hit_pass || hit_con || DataAdr == SCRATCH_ADDR;
    assign t_last   = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign done     = status != ST_RUN;
    always_comb begin
        status_nx = status;
        if (store)
            status_nx = hit_pass ? (WriteData == PASS_DATA ? ST_PASS : ST_FAIL)
                                 : (legal ? ST_RUN : ST_FAIL);
        else if (status == ST_RUN && t_last)
            status_nx = ST_TIMEOUT;
    end
    // the timeout counter parks on its last value, so a legal store on the
    // final cycle defers TIMEOUT to the next store-free cycle instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status    <= ST_RUN;
            tcnt      <= '0;
            store_cnt <= '0;
        end else begin
            status <= status_nx;
            if (status == ST_RUN && !t_last) tcnt <= tcnt + 1'b1;
            if (store && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
        end
    end
`ifdef MMIO_RESULT_PORT_CONSOLE_EN
    logic drop;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store && hit_con),
        .din   (WriteData[7:0]),
        .drop  (drop),
        .valid (con_valid),
        .ready (con_ready),
        .dout  (con_data)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end
`else
    logic unused_console;
    assign unused_console = con_ready | (FIFO_DEPTH > 0);
    assign con_valid = 1'b0;
    assign con_data  = 8'd0;
    assign overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_result_port.sv
// tb_mmio_result_port: randomized and directed checks of mmio_result_port against a queue-based model
module tb_mmio_result_port;
    localparam int T = 16;
`ifdef MMIO_RESULT_PORT_CONSOLE_EN
    localparam bit CON = 1'b1;
`else
    localparam bit CON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic con_ready = 1'b0;
    logic con_valid, done, overflow;
    logic [7:0] con_data;
    logic [1:0] status;
    logic [15:0] store_cnt;
    int checks = 0;
    int failures = 0;
    // model state: verdict 0..3 = RUN/PASS/FAIL/TIMEOUT
    logic [1:0] m_st;
    int m_cnt, m_run;
    bit m_ovf;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    mmio_result_port #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .con_data  (con_data),
        .status    (status),
        .done      (done),
        .store_cnt (store_cnt),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic rn);
        int sz;
        bit pop;
        MemWrite = we; DataAdr = a; WriteData = d; con_ready = rdy; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            m_st = 2'd0; m_cnt = 0; m_run = 0; m_ovf = 0; q.delete();
        end else begin
            sz  = q.size();
            pop = CON && sz > 0 && rdy;
            if (pop) void'(q.pop_front());
            if (m_st == 2'd0) begin
                m_run++;
                if (we) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (CON && a == 32'hF00) begin
                        if (sz < 8 || pop) q.push_back(d[7:0]);
                        else m_ovf = 1;
                    end
                    if (a == 32'd100) m_st = (d == 32'd25) ? 2'd1 : 2'd2;
                    else if (a != 32'd96 && a != 32'hF00) m_st = 2'd2;
                end else if (m_run >= T) m_st = 2'd3;
            end
        end
        #1;
        check("status", status, m_st);
        check("done", done, m_st != 2'd0);
        check("store_cnt", store_cnt, m_cnt);
        check("con_valid", con_valid, q.size() > 0);
        if (q.size() > 0) check("con_data", con_data, q[0]);
        else if (!CON) check("con_data", con_data, 0);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 0, 0, rdy, 1'b1);
    endtask

    task automatic rst();
        step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        logic [31:0] a, d;
        logic [7:0] ch;
        rst();
        check("rst_status", status, 0);
        check("rst_cnt", store_cnt, 0);
        // pass sequence
        step(1'b1, 32'd96, 32'd7, 1'b0, 1'b1);
        check("t1_run", status, 0);
        step(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
        check("t1_pass", status, 1);
        check("t1_done", done, 1);
        check("t1_cnt", store_cnt, 2);
        // fail sequences
        rst();
        step(1'b1, 32'd100, 32'd24, 1'b0, 1'b1);
        check("t2_baddata", status, 2);
        rst();
        step(1'b1, 32'h200, 32'd25, 1'b0, 1'b1);
        check("t2_badaddr", status, 2);
        step(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
        check("t2_sticky", status, 2);
        check("t2_cnt", store_cnt, 1);
        // timeout boundary
        rst();
        for (int i = 0; i < T - 1; i++) idle(1'b0);
        check("t3_pre", status, 0);
        idle(1'b0);
        check("t3_timeout", status, 3);
        rst();
        for (int i = 0; i < T - 1; i++) idle(1'b0);
        step(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
        check("t3_passwins", status, 1);
        // console overflow and drain
        rst();
        for (int i = 0; i < 9; i++) step(1'b1, 32'hF00, 32'h41 + i, 1'b0, 1'b1);
        check("t4_ovf", overflow, CON);
        check("t4_cnt", store_cnt, 9);
        check("t4_status", status, 0);
        if (CON) begin
            for (int i = 0; i < 8; i++) begin
                ch = 8'h41 + 8'(i);
                check("t4_drain", con_data, ch);
                idle(1'b1);
            end
            check("t4_empty", con_valid, 0);
        end
        // full with simultaneous push and pop
        rst();
        for (int i = 0; i < 8; i++) step(1'b1, 32'hF00, 32'h61 + i, 1'b0, 1'b1);
        step(1'b1, 32'hF00, 32'h7A, 1'b1, 1'b1);
        check("t5_noovf", overflow, 0);
        n = 0;
        for (int i = 0; i < 12 && con_valid; i++) begin
            idle(1'b1);
            n++;
        end
        check("t5_occ", n, CON ? 8 : 0);
        // reset mid-run with bytes queued
        rst();
        for (int i = 0; i < 3; i++) step(1'b1, 32'hF00, 32'h30 + i, 1'b0, 1'b1);
        check("t6_queued", con_valid, CON);
        step(1'b1, 32'hF00, 32'h33, 1'b0, 1'b0);
        check("t6_valid", con_valid, 0);
        check("t6_cnt", store_cnt, 0);
        check("t6_status", status, 0);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            n = $urandom_range(0, 99);
            d = $urandom;
            if (n < 35) a = 32'd96;
            else if (n < 75) a = 32'hF00;
            else if (n < 82) begin
                a = 32'd100;
                d = $urandom_range(0, 1) ? 32'd25 : 32'($urandom_range(20, 30));
            end else if (n < 85) a = $urandom;
            else a = 32'd0;
            step(n < 85, a, d, $urandom_range(0, 3) != 0, $urandom_range(0, 29) != 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
